// File: rtl/register_file_if.sv
// Register-file port bundle: one write port and two combinational read ports.
// The datapath side drives through the master modport, the register file
// sits on the slave modport.
interface register_file_if #(
  parameter int N    = 8,
  parameter int ADDR = 2
);
  logic            regWrite;
  logic [ADDR-1:0] writeReg;
  logic [N-1:0]    writeData;
  logic [ADDR-1:0] readReg1;
  logic [ADDR-1:0] readReg2;
  logic [N-1:0]    readData1;
  logic [N-1:0]    readData2;

  modport master (
    output regWrite, writeReg, writeData, readReg1, readReg2,
    input  readData1, readData2
  );

  modport slave (
    input  regWrite, writeReg, writeData, readReg1, readReg2,
    output readData1, readData2
  );
endinterface

// File: rtl/register_file.sv
// NanoRisc register bank: REGS x N flops, one synchronous write port fed by
// the write-back mux, two zero-latency read ports for the ALU operands.
// With BYPASS=1 a same-cycle write is forwarded to matching read ports.
// REGS must equal 2**ADDR (power of two, >= 2); every index is writable.
module register_file #(
  parameter int N      = 8,
  parameter int REGS   = 4,
  parameter int ADDR   = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  register_file_if.slave rf
);

  logic [REGS-1:0][N-1:0] regs_q, regs_d;
  logic                   fwd_en;
  logic [1:0][ADDR-1:0]   rd_addr;
  logic [1:0][N-1:0]      rd_data;

  // Next-state: only the addressed register takes writeData; others hold.
  always_comb begin
    regs_d = regs_q;
    if (rf.regWrite) regs_d[rf.writeReg] = rf.writeData;
  end

  // Storage update; reset clears everything and overrides a pending write.
  always_ff @(posedge clock) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  // Forwarding is only legal when the write will actually land this edge.
  assign fwd_en = BYPASS && rf.regWrite && !reset;

  assign rd_addr[0] = rf.readReg1;
  assign rd_addr[1] = rf.readReg2;

  // Both read ports share identical mux + bypass logic.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    // Read mux with optional write-to-read forwarding.
    always_comb begin
      rd_data[p] = regs_q[rd_addr[p]];
      if (fwd_en && (rd_addr[p] == rf.writeReg)) rd_data[p] = rf.writeData;
    end
  end

  assign rf.readData1 = rd_data[0];
  assign rf.readData2 = rd_data[1];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a BYPASS=1 and a BYPASS=0 instance share one
// stimulus stream; an array model of the register contents predicts reads.
module tb_register_file;

  logic clock = 1'b0;
  logic rst_v;
  logic we_v;
  logic [1:0] wa_v, r1_v, r2_v;
  logic [7:0] wd_v;

  int tests = 0;
  int fails = 0;
  bit inited = 0;
  logic [7:0] m [4];

  always #5 clock = ~clock;

  register_file_if #(.N(8), .ADDR(2)) if1 ();
  register_file_if #(.N(8), .ADDR(2)) if0 ();

  assign if1.regWrite = we_v;  assign if0.regWrite = we_v;
  assign if1.writeReg = wa_v;  assign if0.writeReg = wa_v;
  assign if1.writeData = wd_v; assign if0.writeData = wd_v;
  assign if1.readReg1 = r1_v;  assign if0.readReg1 = r1_v;
  assign if1.readReg2 = r2_v;  assign if0.readReg2 = r2_v;

  register_file #(.N(8), .REGS(4), .ADDR(2), .BYPASS(1'b1)) dut1 (
    .clock(clock), .reset(rst_v), .rf(if1.slave));
  register_file #(.N(8), .REGS(4), .ADDR(2), .BYPASS(1'b0)) dut0 (
    .clock(clock), .reset(rst_v), .rf(if0.slave));

  // Expected read: new write data if forwarding applies, else stored value.
  function automatic logic [7:0] exp_rd(input logic [1:0] a, input bit byp);
    if (byp && we_v && !rst_v && a == wa_v) return wd_v;
    return m[a];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set(input bit rs, input bit we, input logic [1:0] wa,
                     input logic [7:0] wd, input logic [1:0] r1, input logic [1:0] r2);
    rst_v = rs; we_v = we; wa_v = wa; wd_v = wd; r1_v = r1; r2_v = r2;
  endtask

  // One clock: check reads mid-cycle against the model, take the edge,
  // advance the model, land 1 time unit after the edge.
  task automatic cyc(input string tag);
    #2;
    if (inited) begin
      chk({tag, "/b1.rd1"}, if1.readData1, exp_rd(r1_v, 1));
      chk({tag, "/b1.rd2"}, if1.readData2, exp_rd(r2_v, 1));
      chk({tag, "/b0.rd1"}, if0.readData1, exp_rd(r1_v, 0));
      chk({tag, "/b0.rd2"}, if0.readData2, exp_rd(r2_v, 0));
    end
    @(posedge clock);
    if (rst_v) begin
      for (int i = 0; i < 4; i++) m[i] = 8'h00;
      inited = 1;
    end else if (we_v) m[wa_v] = wd_v;
    #1;
  endtask

  initial begin
    logic [7:0] v;
    // Initial reset; nothing is checked before this edge.
    set(1, 0, 0, 0, 0, 0);
    cyc("init");

    // Reset clear with a competing write to r2.
    for (int i = 0; i < 4; i++) begin
      set(0, 1, 2'(i), 8'hAA, 2'(i), 2'(i));
      cyc("fillAA");
    end
    set(1, 1, 2, 8'h55, 2, 2);
    cyc("rst_clr");
    set(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      r1_v = 2'(i); r2_v = 2'(i); #1;
      chk("rst_clr_b1", if1.readData1, 8'h00);
      chk("rst_clr_b0", if0.readData2, 8'h00);
    end

    // Basic write/read.
    set(0, 1, 1, 8'd22, 0, 0); cyc("wr_r1");
    set(0, 1, 3, 8'd14, 0, 0); cyc("wr_r3");
    set(0, 0, 0, 0, 1, 3); #1;
    chk("basic_rd1", if1.readData1, 8'd22);
    chk("basic_rd2", if0.readData2, 8'd14);
    cyc("basic");

    // Write enable gating.
    set(0, 0, 1, 8'd70, 1, 1); cyc("gate");
    chk("gate_r1", if1.readData1, 8'd22);
    chk("gate_r1_b0", if0.readData1, 8'd22);

    // Bypass: r2=17 then same-cycle write of 70 read on both ports.
    set(0, 1, 2, 8'd17, 0, 0); cyc("wr_r2");
    set(0, 1, 2, 8'd70, 2, 2); #1;
    chk("byp1_pre_rd1", if1.readData1, 8'd70);
    chk("byp1_pre_rd2", if1.readData2, 8'd70);
    chk("byp0_pre_rd1", if0.readData1, 8'd17);
    chk("byp0_pre_rd2", if0.readData2, 8'd17);
    cyc("byp");
    we_v = 0; #1;
    chk("byp1_post", if1.readData1, 8'd70);
    chk("byp0_post", if0.readData2, 8'd70);

    // Bypass suppressed while reset is high.
    set(0, 1, 1, 8'd33, 0, 0); cyc("wr_r1b");
    set(1, 1, 1, 8'd99, 1, 1); #1;
    chk("rst_nobyp", if1.readData1, 8'd33);
    cyc("rst_nobyp");

    // Full sweep of read pairs.
    for (int i = 0; i < 4; i++) begin
      set(0, 1, 2'(i), 8'(i * 16 + 5), 0, 0);
      cyc("sweep_wr");
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        set(0, 0, 0, 0, 2'(i), 2'(j)); #1;
        chk("sweep_rd1", if1.readData1, 8'(i * 16 + 5));
        chk("sweep_rd2", if0.readData2, 8'(j * 16 + 5));
        cyc("sweep");
      end
    set(0, 1, 0, 8'hFF, 0, 0); cyc("wr_ff");
    we_v = 0; #1;
    chk("ff_b1", if1.readData1, 8'd255);
    chk("ff_b0", if0.readData1, 8'd255);

    // Mid-stream reset on the 3rd of back-to-back writes.
    set(0, 1, 0, 8'h01, 0, 1); cyc("ms1");
    set(0, 1, 1, 8'h02, 0, 1); cyc("ms2");
    set(1, 1, 3, 8'h03, 0, 1); cyc("ms3");
    set(0, 1, 0, 8'h44, 1, 3); cyc("ms4");
    set(0, 0, 0, 0, 0, 1); #1;
    chk("ms_r0", if1.readData1, 8'h44);
    chk("ms_r1", if0.readData2, 8'h00);
    r1_v = 2; r2_v = 3; #1;
    chk("ms_r2", if0.readData1, 8'h00);
    chk("ms_r3", if1.readData2, 8'h00);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 300; k++) begin
      v = 8'($urandom);
      set($urandom_range(15) == 0, 1'($urandom), 2'($urandom), v,
          2'($urandom), 2'($urandom));
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
